// File: rtl/chaos_pkg.sv
// Shared types and the tent-map fold for the chaos step engine.
// The fold works on a wide vector so any lane width up to MAX_W can use it.
package chaos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  // Tent fold on the low w bits: double, and mirror when the top bit was set.
  function automatic logic [MAX_W-1:0] tent_step(input logic [MAX_W-1:0] s, input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] dbl;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    dbl  = (s << 1) & mask;
    return s[w-1] ? (~dbl & mask) : dbl;
  endfunction

endpackage

// File: rtl/chaos_fifo.sv
// Show-ahead register FIFO: rd_data is the head whenever empty is low.
// A synchronous flush empties it; pops while empty and pushes while full are ignored.
module chaos_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: storage is deliberately not reset; the pointers and level alone
  // decide which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));

endmodule

// File: rtl/chaos_step_engine.sv
// Coupled tent-map engine: CHANNELS lanes perturbed by a rotating seed word,
// run in bursts or free-run, with results queued in a show-ahead FIFO.
module chaos_step_engine
  import chaos_pkg::*;
#(
  parameter  int CHANNELS   = 4,
  parameter  int WIDTH      = 8,
  parameter  int SEED_W     = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int DW         = CHANNELS * WIDTH,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic [SEED_W-1:0] seed,
  input  logic              step,
  input  logic              mode,
  input  logic [15:0]       count,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level
);

  if (DW > SEED_W) begin : g_bad_seed_w
    $error("chaos_step_engine: CHANNELS*WIDTH must not exceed SEED_W");
  end
  if (WIDTH > MAX_W) begin : g_bad_width
    $error("chaos_step_engine: WIDTH exceeds chaos_pkg::MAX_W");
  end

  state_e                         state, state_nx;
  logic                           step_q;
  logic                           rise;
  logic                           run_mode, run_mode_nx;
  logic [15:0]                    ctr, ctr_nx;
  logic [15:0]                    count_eff;
  logic [CHANNELS-1:0][WIDTH-1:0] lanes, lanes_nx;
  logic [CHANNELS-1:0][WIDTH-1:0] lanes_seed;
  logic [CHANNELS-1:0][WIDTH-1:0] lanes_iter;
  logic [SEED_W-1:0]              pert, pert_nx;
  logic                           push;

  assign rise      = step && !step_q;
  assign count_eff = (count == 16'd0) ? 16'd1 : count;

  // Both candidate next vectors are formed every cycle; the FSM picks one.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lanes_seed[i] = seed[i*WIDTH +: WIDTH] ^ WIDTH'(i + 1);
      lanes_iter[i] = (WIDTH'(tent_step(MAX_W'(lanes[i]), WIDTH))
                       ^ (lanes[(i + 1) % CHANNELS] >> 1))
                      + pert[WIDTH-1:0];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx    = state;
    run_mode_nx = run_mode;
    ctr_nx      = ctr;
    lanes_nx    = lanes;
    pert_nx     = pert;
    push        = 1'b0;

    if (soft_reset) begin
      state_nx = IDLE;
      lanes_nx = lanes_seed;
      pert_nx  = seed;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nx    = RUN;
            lanes_nx    = lanes_seed;
            pert_nx     = seed;
            ctr_nx      = count_eff;
            run_mode_nx = mode;
          end
        end
        RUN: begin
          if (run_mode && !step) begin
            state_nx = DONE;
          end else if (!full) begin
            push     = 1'b1;
            lanes_nx = lanes_iter;
            pert_nx  = {pert[SEED_W-2:0], pert[SEED_W-1]};
            if (!run_mode) begin
              if (ctr == 16'd1) state_nx = DONE;
              else              ctr_nx   = ctr - 16'd1;
            end
          end
        end
        DONE: begin
          // Continuation keeps lanes and perturbation where they stopped.
          if (rise) begin
            state_nx    = RUN;
            ctr_nx      = count_eff;
            run_mode_nx = mode;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values, matching the all-lanes-at-once update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_q   <= 1'b0;
      run_mode <= 1'b0;
      ctr      <= '0;
      lanes    <= '0;
      pert     <= '0;
    end else begin
      state    <= state_nx;
      step_q   <= step;
      run_mode <= run_mode_nx;
      ctr      <= ctr_nx;
      lanes    <= lanes_nx;
      pert     <= pert_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  chaos_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (soft_reset),
    .push    (push),
    .wr_data (lanes_iter),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

endmodule

// File: tb/tb_chaos_step_engine.sv
// Scoreboard bench for chaos_step_engine at default parameters (4 x 8-bit lanes).
// A lane-level model predicts every pushed vector; reads compare against the queue.
module tb_chaos_step_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        soft_reset;
  logic [31:0] seed;
  logic        step;
  logic        mode;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  level;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  m_s[4];
  logic [31:0] m_p;

  chaos_step_engine dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .seed       (seed),
    .step       (step),
    .mode       (mode),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic m_load(input logic [31:0] sd);
    for (int i = 0; i < 4; i++) m_s[i] = sd[i*8 +: 8] ^ 8'(i + 1);
    m_p = sd;
  endtask

  task automatic m_run(input int n);
    logic [7:0] ns[4];
    logic [7:0] d;
    logic [7:0] t;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        d = m_s[i] << 1;
        t = m_s[i][7] ? ~d : d;
        ns[i] = (t ^ (m_s[(i + 1) % 4] >> 1)) + m_p[7:0];
      end
      m_s = ns;
      m_p = {m_p[30:0], m_p[31]};
      exp_q.push_back({m_s[3], m_s[2], m_s[1], m_s[0]});
    end
  endtask

  task automatic do_soft_reset(input logic [31:0] sd);
    seed = sd;
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    exp_q.delete();
    m_load(sd);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s: done=%b expected 1 within %0d cycles", name, done, budget);
    end
  endtask

  task automatic drain(input int n, input string name);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s: read %0d has no expected entry (got %h)", name, k, rd_data);
      end else begin
        e = exp_q.pop_front();
        if (empty !== 1'b0 || rd_data !== e) begin
          bad++;
          $display("FAIL %s: read %0d rd_data=%h empty=%b expected %h empty=0",
                   name, k, rd_data, empty, e);
        end
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, empty, full, level} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b empty=%b full=%b level=%0d expected 0 0 1 0 0",
               busy, done, empty, full, level);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lane_iter();
    do_soft_reset(32'h0000_0000);
    mode = 1'b0;
    count = 16'd1;
    m_run(1);
    pulse_step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL lane_busy: busy=%b expected 1", busy);
    end
    wait_done(5, "lane_done");
    total++;
    if (level !== 5'd1 || rd_data !== 32'h0804_0503) begin
      bad++;
      $display("FAIL lane_value: level=%0d rd_data=%h expected 1 08040503", level, rd_data);
    end
    drain(1, "lane_sb");
  endtask

  task automatic test_tent_fold();
    do_soft_reset(32'hFF00_0000);
    count = 16'd1;
    m_run(1);
    pulse_step();
    wait_done(5, "fold_done");
    total++;
    if (rd_data !== 32'h097B_0503) begin
      bad++;
      $display("FAIL fold_value: rd_data=%h expected 097b0503", rd_data);
    end
    drain(1, "fold_sb");
    // count of zero behaves as a single iteration, continuing from the last state
    count = 16'd0;
    m_run(1);
    pulse_step();
    wait_done(5, "count0_done");
    total++;
    if (level !== 5'd1) begin
      bad++;
      $display("FAIL count0_level: level=%0d expected 1", level);
    end
    drain(1, "count0_sb");
  endtask

  task automatic test_back_pressure();
    do_soft_reset(32'h1234_5678);
    mode = 1'b0;
    count = 16'd20;
    m_run(20);
    pulse_step();
    repeat (22) @(negedge clk);
    total++;
    if ({level, full, busy, done} !== {5'd16, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bp_stall: level=%0d full=%b busy=%b done=%b expected 16 1 1 0",
               level, full, busy, done);
    end
    drain(4, "bp_pop");
    wait_done(20, "bp_done");
    total++;
    if (level !== 5'd16 || full !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_final: level=%0d full=%b busy=%b expected 16 1 0", level, full, busy);
    end
    drain(16, "bp_sb");
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL bp_empty: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_free_run();
    do_soft_reset(32'hDEAD_BEEF);
    mode = 1'b1;
    m_run(9);
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    wait_done(5, "free_done");
    total++;
    if (level !== 5'd9) begin
      bad++;
      $display("FAIL free_level: level=%0d expected 9", level);
    end
    // continuation: no reload, model state carries on
    mode = 1'b0;
    count = 16'd3;
    m_run(3);
    pulse_step();
    wait_done(8, "cont_done");
    total++;
    if (level !== 5'd12) begin
      bad++;
      $display("FAIL cont_level: level=%0d expected 12", level);
    end
    drain(12, "free_sb");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_soft_reset(32'h0F1E_2D3C);
    mode = 1'b0;
    count = 16'd5;
    m_run(5);
    pulse_step();
    wait_done(10, "b2b_fill");
    count = 16'd8;
    m_run(8);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      total++;
      if (level !== 5'd5 || rd_data !== e) begin
        bad++;
        $display("FAIL b2b_cycle%0d: level=%0d rd_data=%h expected 5 %h", k, level, rd_data, e);
      end
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
    total++;
    if (level !== 5'd5 || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end: level=%0d done=%b expected 5 1", level, done);
    end
    drain(5, "b2b_sb");
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    total++;
    if ({level, empty, full} !== {5'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL empty_read: level=%0d empty=%b full=%b expected 0 1 0", level, empty, full);
    end
  endtask

  task automatic test_soft_reset_run();
    do_soft_reset(32'hA5C3_0F17);
    count = 16'd20;
    pulse_step();
    repeat (6) @(negedge clk);
    do_soft_reset(32'h5A3C_F071);
    total++;
    if ({busy, done, empty, level} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL soft_flush: busy=%b done=%b empty=%b level=%0d expected 0 0 1 0",
               busy, done, empty, level);
    end
    count = 16'd1;
    m_run(1);
    pulse_step();
    wait_done(5, "soft_done");
    drain(1, "soft_sb");
  endtask

  task automatic test_async_reset();
    do_soft_reset(32'h7777_1111);
    count = 16'd10;
    pulse_step();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, empty, full, level} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b empty=%b full=%b level=%0d expected 0 0 1 0 0",
               busy, done, empty, full, level);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    soft_reset = 1'b0;
    seed = '0;
    step = 1'b0;
    mode = 1'b0;
    count = 16'd1;
    rd_en = 1'b0;
    test_reset();
    test_lane_iter();
    test_tent_fold();
    test_back_pressure();
    test_free_run();
    test_back_to_back();
    test_soft_reset_run();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
